// File: rtl/stack_xfer_seq_if.sv
// Request/response bundle between opcode decode and the stack-transfer sequencer.
// master = decode side issuing requests, slave = sequencer.
interface stack_xfer_seq_if #(
  parameter int unsigned PC_WORDS = 2
);
  localparam int unsigned SEL_W = $clog2(PC_WORDS + 2);

  logic             call;
  logic             ret;
  logic             rti;
  logic             irq;
  logic             hazard_stall;
  logic             irq_ack;
  logic             stack;
  logic             mem_wr;
  logic             mem_rd;
  logic [SEL_W-1:0] mem_data_sel;
  logic [SEL_W-1:0] pop_sel;
  logic [1:0]       pc_sel;
  logic             freeze_pc;
  logic             freeze_cu;
  logic             flush;
  logic             busy;

  modport master (
    output call, ret, rti, irq, hazard_stall,
    input  irq_ack, stack, mem_wr, mem_rd, mem_data_sel, pop_sel,
           pc_sel, freeze_pc, freeze_cu, flush, busy
  );

  modport slave (
    input  call, ret, rti, irq, hazard_stall,
    output irq_ack, stack, mem_wr, mem_rd, mem_data_sel, pop_sel,
           pc_sel, freeze_pc, freeze_cu, flush, busy
  );
endinterface

// File: rtl/stack_xfer_seq.sv
// Stack-transfer sequencer for CALL, RET, INT and RTI: pushes/pops the PC words
// (plus CCR on interrupts) and steers fetch/decode freeze, flush and PC select.
module stack_xfer_seq #(
  parameter int unsigned PC_WORDS = 2,
  parameter int unsigned SAVE_CCR = 1,
  parameter int unsigned RET_WAIT = 2
) (
  input  logic                clk,
  input  logic                rst,
  stack_xfer_seq_if.slave     bus
);
  localparam int unsigned SEL_W = $clog2(PC_WORDS + 2);

  localparam logic [SEL_W-1:0] CNT_ZERO  = SEL_W'(0);
  localparam logic [SEL_W-1:0] CNT_ONE   = SEL_W'(1);
  localparam logic [SEL_W-1:0] CNT_PC    = SEL_W'(PC_WORDS);
  localparam logic [SEL_W-1:0] CNT_WAIT  = SEL_W'(RET_WAIT);
  localparam logic [SEL_W-1:0] CNT_OUTER = (SAVE_CCR != 0) ? SEL_W'(PC_WORDS + 1) : SEL_W'(PC_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALL_PUSH,
    S_RET_WAIT,
    S_POP,
    S_INT_WAIT,
    S_INT_WAIT2,
    S_INT_FRZ,
    S_PUSH
  } state_t;

  state_t           state;
  state_t           nxt_state;
  logic [SEL_W-1:0] cnt;
  logic [SEL_W-1:0] nxt_cnt;
  logic             irq_pend;
  logic             take_irq;

  logic             stack_d;
  logic             mem_wr_d;
  logic             mem_rd_d;
  logic [SEL_W-1:0] mem_data_sel_d;
  logic [SEL_W-1:0] pop_sel_d;
  logic [1:0]       pc_sel_d;
  logic             freeze_pc_d;
  logic             freeze_cu_d;
  logic             flush_d;

  // Capture is visible in the same cycle the interrupt line is first seen.
  assign bus.irq_ack = rst & bus.irq & ~irq_pend;

  // Next state and word counter; the counter holds the select value of the current word.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    take_irq  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.call) begin
          nxt_state = S_CALL_PUSH;
          nxt_cnt   = CNT_ONE;
        end else if (bus.ret) begin
          if (RET_WAIT == 0) begin
            nxt_state = S_POP;
            nxt_cnt   = CNT_PC;
          end else begin
            nxt_state = S_RET_WAIT;
            nxt_cnt   = CNT_ONE;
          end
        end else if (bus.rti) begin
          nxt_state = S_POP;
          nxt_cnt   = CNT_OUTER;
        end else if (irq_pend || bus.irq) begin
          nxt_state = S_INT_WAIT;
          nxt_cnt   = CNT_ZERO;
          take_irq  = 1'b1;
        end
      end
      S_CALL_PUSH: begin
        if (cnt == CNT_PC) begin
          nxt_state = S_IDLE;
          nxt_cnt   = CNT_ZERO;
        end else begin
          nxt_cnt = cnt + CNT_ONE;
        end
      end
      S_RET_WAIT: begin
        if (cnt == CNT_WAIT) begin
          nxt_state = S_POP;
          nxt_cnt   = CNT_PC;
        end else begin
          nxt_cnt = cnt + CNT_ONE;
        end
      end
      S_POP: begin
        if (cnt == CNT_ONE) begin
          nxt_state = S_IDLE;
          nxt_cnt   = CNT_ZERO;
        end else begin
          nxt_cnt = cnt - CNT_ONE;
        end
      end
      S_INT_WAIT: begin
        nxt_state = bus.hazard_stall ? S_INT_WAIT2 : S_INT_FRZ;
        nxt_cnt   = CNT_ZERO;
      end
      S_INT_WAIT2: begin
        nxt_state = S_INT_FRZ;
        nxt_cnt   = CNT_ZERO;
      end
      S_INT_FRZ: begin
        nxt_state = S_PUSH;
        nxt_cnt   = CNT_ONE;
      end
      S_PUSH: begin
        if (cnt == CNT_OUTER) begin
          nxt_state = S_IDLE;
          nxt_cnt   = CNT_ZERO;
        end else begin
          nxt_cnt = cnt + CNT_ONE;
        end
      end
      default: begin
        nxt_state = S_IDLE;
        nxt_cnt   = CNT_ZERO;
      end
    endcase
  end

  // Moore decode of the upcoming state so the registered outputs line up with it.
  always_comb begin
    stack_d        = 1'b0;
    mem_wr_d       = 1'b0;
    mem_rd_d       = 1'b0;
    mem_data_sel_d = CNT_ZERO;
    pop_sel_d      = CNT_ZERO;
    pc_sel_d       = 2'b00;
    freeze_pc_d    = 1'b0;
    freeze_cu_d    = 1'b0;
    flush_d        = 1'b0;
    case (nxt_state)
      S_CALL_PUSH: begin
        stack_d        = 1'b1;
        mem_wr_d       = 1'b1;
        mem_data_sel_d = nxt_cnt;
        if (nxt_cnt == CNT_ONE) pc_sel_d = 2'b11;
        flush_d        = (nxt_cnt == CNT_PC);
      end
      S_POP: begin
        stack_d     = 1'b1;
        mem_rd_d    = 1'b1;
        freeze_pc_d = 1'b1;
        freeze_cu_d = 1'b1;
        pop_sel_d   = nxt_cnt;
        if (nxt_cnt == CNT_ONE) begin
          pc_sel_d = 2'b01;
          flush_d  = 1'b1;
        end
      end
      S_INT_FRZ: begin
        freeze_pc_d = 1'b1;
      end
      S_PUSH: begin
        stack_d        = 1'b1;
        mem_wr_d       = 1'b1;
        freeze_pc_d    = 1'b1;
        freeze_cu_d    = 1'b1;
        mem_data_sel_d = nxt_cnt;
        if (nxt_cnt == CNT_OUTER) pc_sel_d = 2'b10;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= S_IDLE;
      cnt              <= CNT_ZERO;
      irq_pend         <= 1'b0;
      bus.busy         <= 1'b0;
      bus.stack        <= 1'b0;
      bus.mem_wr       <= 1'b0;
      bus.mem_rd       <= 1'b0;
      bus.mem_data_sel <= CNT_ZERO;
      bus.pop_sel      <= CNT_ZERO;
      bus.pc_sel       <= 2'b00;
      bus.freeze_pc    <= 1'b0;
      bus.freeze_cu    <= 1'b0;
      bus.flush        <= 1'b0;
    end else begin
      state            <= nxt_state;
      cnt              <= nxt_cnt;
      // Entry into INT consumes the pending request, even one raised this cycle.
      if (take_irq)     irq_pend <= 1'b0;
      else if (bus.irq) irq_pend <= 1'b1;
      bus.busy         <= (nxt_state != S_IDLE);
      bus.stack        <= stack_d;
      bus.mem_wr       <= mem_wr_d;
      bus.mem_rd       <= mem_rd_d;
      bus.mem_data_sel <= mem_data_sel_d;
      bus.pop_sel      <= pop_sel_d;
      bus.pc_sel       <= pc_sel_d;
      bus.freeze_pc    <= freeze_pc_d;
      bus.freeze_cu    <= freeze_cu_d;
      bus.flush        <= flush_d;
    end
  end
endmodule

// File: tb/tb_stack_xfer_seq.sv
// Directed bench for stack_xfer_seq with PC_WORDS=2, SAVE_CCR=1, RET_WAIT=2.
module tb_stack_xfer_seq;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  stack_xfer_seq_if #(.PC_WORDS(2)) bus ();

  stack_xfer_seq #(.PC_WORDS(2), .SAVE_CCR(1), .RET_WAIT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [13:0] Z = 14'd0;

  logic [13:0] obs;
  assign obs = {bus.busy, bus.stack, bus.mem_wr, bus.mem_rd, bus.mem_data_sel, bus.pop_sel,
                bus.pc_sel, bus.freeze_pc, bus.freeze_cu, bus.flush, bus.irq_ack};

  // Builds an expected output vector in the same field order as obs.
  function automatic logic [13:0] ev(input int b, input int st, input int wr, input int rd,
                                     input int ds, input int ps, input int pc,
                                     input int fp, input int fc, input int fl, input int ak);
    return {1'(b), 1'(st), 1'(wr), 1'(rd), 2'(ds), 2'(ps), 2'(pc),
            1'(fp), 1'(fc), 1'(fl), 1'(ak)};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.call = 1'b0; bus.ret = 1'b0; bus.rti = 1'b0; bus.irq = 1'b0; bus.hazard_stall = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] e [5];
    e = '{Z, Z, Z, Z, Z};
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin rst = 1'b1; clear_inputs(); end
      #1;
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL reset cyc %0d: got %b want %b", i, obs, e[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_call();
    logic [13:0] e [4];
    e = '{Z, ev(1,1,1,0,1,0,3,0,0,0,0), ev(1,1,1,0,2,0,0,0,0,1,0), Z};
    for (int i = 0; i < 4; i++) begin
      bus.call = (i == 0);
      #1;
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL call cyc %0d: got %b want %b", i, obs, e[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_ret();
    logic [13:0] e [6];
    e = '{Z, ev(1,0,0,0,0,0,0,0,0,0,0), ev(1,0,0,0,0,0,0,0,0,0,0),
          ev(1,1,0,1,0,2,0,1,1,0,0), ev(1,1,0,1,0,1,1,1,1,1,0), Z};
    for (int i = 0; i < 6; i++) begin
      bus.ret = (i == 0);
      #1;
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL ret cyc %0d: got %b want %b", i, obs, e[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_int_stall();
    logic [13:0] e [8];
    e = '{ev(0,0,0,0,0,0,0,0,0,0,1), ev(1,0,0,0,0,0,0,0,0,0,0), ev(1,0,0,0,0,0,0,0,0,0,0),
          ev(1,0,0,0,0,0,0,1,0,0,0), ev(1,1,1,0,1,0,0,1,1,0,0), ev(1,1,1,0,2,0,0,1,1,0,0),
          ev(1,1,1,0,3,0,2,1,1,0,0), Z};
    for (int i = 0; i < 8; i++) begin
      bus.irq          = (i == 0);
      bus.hazard_stall = (i == 1);
      #1;
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL int_stall cyc %0d: got %b want %b", i, obs, e[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_int_no_stall();
    logic [13:0] e [7];
    e = '{ev(0,0,0,0,0,0,0,0,0,0,1), ev(1,0,0,0,0,0,0,0,0,0,0), ev(1,0,0,0,0,0,0,1,0,0,0),
          ev(1,1,1,0,1,0,0,1,1,0,0), ev(1,1,1,0,2,0,0,1,1,0,0), ev(1,1,1,0,3,0,2,1,1,0,0), Z};
    for (int i = 0; i < 7; i++) begin
      bus.irq          = (i == 0);
      bus.hazard_stall = (i == 2);
      #1;
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL int_no_stall cyc %0d: got %b want %b", i, obs, e[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_rti_irq();
    logic [13:0] e [11];
    e = '{Z, ev(1,1,0,1,0,3,0,1,1,0,1), ev(1,1,0,1,0,2,0,1,1,0,0), ev(1,1,0,1,0,1,1,1,1,1,0),
          Z, ev(1,0,0,0,0,0,0,0,0,0,0), ev(1,0,0,0,0,0,0,1,0,0,0), ev(1,1,1,0,1,0,0,1,1,0,0),
          ev(1,1,1,0,2,0,0,1,1,0,0), ev(1,1,1,0,3,0,2,1,1,0,0), Z};
    for (int i = 0; i < 11; i++) begin
      bus.rti = (i == 0);
      bus.irq = (i == 1);
      #1;
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL rti_irq cyc %0d: got %b want %b", i, obs, e[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_priority();
    logic [13:0] e [10];
    e = '{ev(0,0,0,0,0,0,0,0,0,0,1), ev(1,1,1,0,1,0,3,0,0,0,0), ev(1,1,1,0,2,0,0,0,0,1,0),
          Z, ev(1,0,0,0,0,0,0,0,0,0,0), ev(1,0,0,0,0,0,0,1,0,0,0), ev(1,1,1,0,1,0,0,1,1,0,0),
          ev(1,1,1,0,2,0,0,1,1,0,0), ev(1,1,1,0,3,0,2,1,1,0,0), Z};
    for (int i = 0; i < 10; i++) begin
      bus.call = (i == 0);
      bus.irq  = (i == 0);
      bus.ret  = (i <= 1);
      bus.rti  = (i <= 1);
      #1;
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL priority cyc %0d: got %b want %b", i, obs, e[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    logic [13:0] e [11];
    e = '{ev(0,0,0,0,0,0,0,0,0,0,1), ev(1,0,0,0,0,0,0,0,0,0,0), ev(1,0,0,0,0,0,0,1,0,0,0),
          ev(1,1,1,0,1,0,0,1,1,0,0), ev(1,1,1,0,2,0,0,1,1,0,0), Z, Z,
          ev(1,1,1,0,1,0,3,0,0,0,0), ev(1,1,1,0,2,0,0,0,0,1,0), Z, Z};
    for (int i = 0; i < 11; i++) begin
      bus.irq  = (i == 0);
      bus.call = (i == 6);
      rst      = (i != 4);
      #1;
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL reset_mid cyc %0d: got %b want %b", i, obs, e[i]);
      end
      next_cycle();
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.call = 1'b1; bus.ret = 1'b1; bus.rti = 1'b1; bus.irq = 1'b1; bus.hazard_stall = 1'b0;
    next_cycle();
    test_reset();
    test_call();
    test_ret();
    test_int_stall();
    test_int_no_stall();
    test_rti_irq();
    test_priority();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
